apb5_requester: RTL and testbench

Synthesizable APB5 requester that converts a valid/ready request channel into APB5 transfers across NUM_OF_SLAVES completers. It sequences PWAKEUP ahead of PSELx, enforces a wait-state timeout, and returns read data and error status on a valid/ready response channel. It sits between an on-chip command source, such as a bus bridge or CSR sequencer, and the APB fabric.

---
 rtl/apb5_requester_if.sv | 77 +++++++
 rtl/apb5_requester.sv | 189 ++++++++++++++++++
 tb/tb_apb5_requester.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb5_requester_if.sv
// Request/response channel plus APB5 requester/completer signals for apb5_requester.
// APB_REQ_PARITY_EN adds the APB5 parity check signals and rsp_parerr.
interface apb5_requester_if #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_OF_SLAVES = 4
);
  localparam int unsigned SW = $clog2(NUM_OF_SLAVES) + 1;

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_strb;
  logic [2:0]                req_prot;
  logic [SW-1:0]             req_sel;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;

  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [2:0]                PPROT;
  logic [NUM_OF_SLAVES-1:0]  PSELx;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic                      PWAKEUP;
  logic                      PREADY;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PSLVERR;

`ifdef APB_REQ_PARITY_EN
  logic [ADDR_WIDTH/8-1:0]   PADDRCHK;
  logic                      PCTRLCHK;
  logic [NUM_OF_SLAVES-1:0]  PSELxCHK;
  logic                      PENABLECHK;
  logic [DATA_WIDTH/8-1:0]   PWDATACHK;
  logic                      PSTRBCHK;
  logic                      PWAKEUPCHK;
  logic                      PREADYCHK;
  logic [DATA_WIDTH/8-1:0]   PRDATACHK;
  logic                      PSLVERRCHK;
  logic                      rsp_parerr;
`endif

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, req_sel,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
    input  PREADY, PRDATA, PSLVERR
`ifdef APB_REQ_PARITY_EN
    , output PADDRCHK, PCTRLCHK, PSELxCHK, PENABLECHK, PWDATACHK, PSTRBCHK, PWAKEUPCHK
    , input  PREADYCHK, PRDATACHK, PSLVERRCHK
    , output rsp_parerr
`endif
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot, req_sel,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
    output PREADY, PRDATA, PSLVERR
`ifdef APB_REQ_PARITY_EN
    , input  PADDRCHK, PCTRLCHK, PSELxCHK, PENABLECHK, PWDATACHK, PSTRBCHK, PWAKEUPCHK
    , output PREADYCHK, PRDATACHK, PSLVERRCHK
    , input  rsp_parerr
`endif
  );
endinterface

// File: rtl/apb5_requester.sv
// APB5 requester: valid/ready request -> PWAKEUP/SETUP/ACCESS -> valid/ready response.
// Optional APB5 parity generation/checking under APB_REQ_PARITY_EN.
module apb5_requester #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_OF_SLAVES  = 4,
  parameter int unsigned WAKEUP_LEAD    = 1,
  parameter int unsigned WAKEUP_HOLD    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb5_requester_if.master  bus
);
  localparam int unsigned SW = $clog2(NUM_OF_SLAVES) + 1;
  localparam int unsigned SB = DATA_WIDTH / 8;
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LEAD_LAST = 4'((WAKEUP_LEAD == 0) ? 0 : WAKEUP_LEAD - 1);
  localparam logic [3:0]    HOLD_LAST = 4'((WAKEUP_HOLD == 0) ? 0 : WAKEUP_HOLD - 1);
  localparam logic [SW-1:0] NSEL      = SW'(NUM_OF_SLAVES);

  typedef enum logic [2:0] {IDLE, WAKE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]    paddr_q;
  logic [DATA_WIDTH-1:0]    pwdata_q;
  logic [SB-1:0]            pstrb_q;
  logic [2:0]               pprot_q;
  logic                     pwrite_q;
  logic [SW-1:0]            sel_q;
  logic                     pwakeup_q;
  logic [3:0]               wk_cnt;
  logic [3:0]               hold_cnt;
  logic [TW-1:0]            wait_cnt;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_q;
  logic                     timeout_q;
  logic [NUM_OF_SLAVES-1:0] psel;

  logic accept, sel_bad, timeout_hit, rsp_hs, in_parerr;

  assign accept      = (state == IDLE) && bus.req_valid;
  assign sel_bad     = (bus.req_sel >= NSEL);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);
  assign rsp_hs      = (state == RESP) && bus.rsp_ready;

`ifdef APB_REQ_PARITY_EN
  logic [SB-1:0] rdchk_exp;
  logic          parerr_q;
  always_comb begin
    rdchk_exp = '0;
    for (int unsigned i = 0; i < SB; i++) rdchk_exp[i] = ~^bus.PRDATA[i*8 +: 8];
  end
  // PRDATACHK is only meaningful on reads; ready/error checks apply to every transfer.
  assign in_parerr = (bus.PREADYCHK != ~bus.PREADY) || (bus.PSLVERRCHK != ~bus.PSLVERR) ||
                     (!pwrite_q && (bus.PRDATACHK != rdchk_exp));
`else
  assign in_parerr = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (sel_bad)                             state_nxt = RESP;
          else if (pwakeup_q || WAKEUP_LEAD == 0)  state_nxt = SETUP;
          else                                     state_nxt = WAKE;
        end
      end
      WAKE:    if (wk_cnt == LEAD_LAST) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.PREADY || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      sel_q     <= '0;
      pwakeup_q <= 1'b0;
      wk_cnt    <= '0;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
`ifdef APB_REQ_PARITY_EN
      parerr_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        paddr_q  <= bus.req_addr;
        pwdata_q <= bus.req_wdata;
        pstrb_q  <= bus.req_write ? bus.req_strb : '0;
        pprot_q  <= bus.req_prot;
        pwrite_q <= bus.req_write;
        sel_q    <= bus.req_sel;
      end

      wk_cnt   <= (state == WAKE)   ? wk_cnt + 4'd1   : '0;
      wait_cnt <= (state == ACCESS) ? wait_cnt + 1'b1 : '0;

      if (accept && sel_bad) begin
        rdata_q   <= '0;
        err_q     <= 1'b1;
        timeout_q <= 1'b0;
`ifdef APB_REQ_PARITY_EN
        parerr_q  <= 1'b0;
`endif
      end else if (state == ACCESS) begin
        if (bus.PREADY) begin
          rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
          err_q     <= bus.PSLVERR | in_parerr;
          timeout_q <= 1'b0;
`ifdef APB_REQ_PARITY_EN
          parerr_q  <= in_parerr;
`endif
        end else if (timeout_hit) begin
          rdata_q   <= '0;
          err_q     <= 1'b1;
          timeout_q <= 1'b1;
`ifdef APB_REQ_PARITY_EN
          parerr_q  <= 1'b0;
`endif
        end
      end

      // Hold window restarts at each response handshake; a decode-error accept leaves PWAKEUP alone.
      if (accept && !sel_bad) begin
        pwakeup_q <= 1'b1;
        hold_cnt  <= '0;
      end else if (rsp_hs) begin
        hold_cnt <= '0;
        if (WAKEUP_HOLD == 0) pwakeup_q <= 1'b0;
      end else if ((state == IDLE) && pwakeup_q && !accept) begin
        if (hold_cnt == HOLD_LAST) pwakeup_q <= 1'b0;
        else                       hold_cnt  <= hold_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    psel = '0;
    for (int unsigned i = 0; i < NUM_OF_SLAVES; i++)
      psel[i] = ((state == SETUP) || (state == ACCESS)) && (sel_q == SW'(i));
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PPROT       = pprot_q;
  assign bus.PSELx       = psel;
  assign bus.PENABLE     = (state == ACCESS);
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PWAKEUP     = pwakeup_q;

`ifdef APB_REQ_PARITY_EN
  always_comb begin
    bus.PADDRCHK  = '0;
    bus.PWDATACHK = '0;
    for (int unsigned i = 0; i < ADDR_WIDTH/8; i++) bus.PADDRCHK[i]  = ~^paddr_q[i*8 +: 8];
    for (int unsigned i = 0; i < SB; i++)           bus.PWDATACHK[i] = ~^pwdata_q[i*8 +: 8];
  end
  assign bus.PCTRLCHK   = ~^{pprot_q, pwrite_q};
  assign bus.PSELxCHK   = ~psel;
  assign bus.PENABLECHK = ~(state == ACCESS);
  assign bus.PSTRBCHK   = ~^pstrb_q;
  assign bus.PWAKEUPCHK = ~pwakeup_q;
  assign bus.rsp_parerr = parerr_q;
`endif
endmodule

// File: tb/tb_apb5_requester.sv
// Directed self-checking bench for apb5_requester (WAKEUP_LEAD=1, WAKEUP_HOLD=2, TIMEOUT_CYCLES=8).
module tb_apb5_requester;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;

  logic PCLK = 1'b0;
  logic PRESETn;
  int   total = 0;
  int   bad   = 0;

  always #5 PCLK = ~PCLK;

  apb5_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OF_SLAVES(NS)) bus ();

  apb5_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_OF_SLAVES(NS),
    .WAKEUP_LEAD(1), .WAKEUP_HOLD(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );

`ifdef APB_REQ_PARITY_EN
  logic [DW/8-1:0] rdchk_flip = '0;
  always_comb begin
    bus.PREADYCHK  = ~bus.PREADY;
    bus.PSLVERRCHK = ~bus.PSLVERR;
    for (int i = 0; i < DW/8; i++) bus.PRDATACHK[i] = (~^bus.PRDATA[i*8 +: 8]) ^ rdchk_flip[i];
  end
`endif

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_strb  = '0;   bus.req_prot  = '0;   bus.req_sel  = '0; bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0; bus.PRDATA    = '0;   bus.PSLVERR  = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] sel);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
    bus.req_strb  = s;    bus.req_prot  = 3'b010; bus.req_sel = sel;
  endtask

  task automatic test_reset();
    PRESETn = 1'b1;
    idle_inputs();
    #1 PRESETn = 1'b0;
    #2;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL rst_psel got=%b exp=0000", bus.PSELx); end
    total++; if (bus.PENABLE !== 1'b0) begin bad++; $display("FAIL rst_penable got=%b exp=0", bus.PENABLE); end
    total++; if (bus.PWAKEUP !== 1'b0) begin bad++; $display("FAIL rst_pwakeup got=%b exp=0", bus.PWAKEUP); end
    total++; if (bus.PADDR !== 32'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", bus.PADDR); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", bus.rsp_err); end
    tick(2);
    PRESETn = 1'b1;
    tick(1);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_write();
    total++; if (bus.PWAKEUP !== 1'b0) begin bad++; $display("FAIL wr_wake_pre got=%b exp=0", bus.PWAKEUP); end
    issue(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 3'd2);
    bus.PREADY = 1'b1;
    tick(1); // WAKE
    bus.req_valid = 1'b0;
    total++; if (bus.PWAKEUP !== 1'b1) begin bad++; $display("FAIL wr_wake_lead got=%b exp=1", bus.PWAKEUP); end
    total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL wr_psel_wake got=%b exp=0000", bus.PSELx); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_busy got=%b exp=0", bus.req_ready); end
    tick(1); // SETUP
    total++; if (bus.PSELx !== 4'b0100) begin bad++; $display("FAIL wr_psel_setup got=%b exp=0100", bus.PSELx); end
    total++; if (bus.PENABLE !== 1'b0) begin bad++; $display("FAIL wr_pen_setup got=%b exp=0", bus.PENABLE); end
    total++; if (bus.PADDR !== 32'h10) begin bad++; $display("FAIL wr_paddr got=%h exp=00000010", bus.PADDR); end
    total++; if (bus.PWDATA !== 32'hA5A5_5A5A) begin bad++; $display("FAIL wr_pwdata got=%h exp=a5a55a5a", bus.PWDATA); end
    total++; if (bus.PSTRB !== 4'hF) begin bad++; $display("FAIL wr_pstrb got=%h exp=f", bus.PSTRB); end
    total++; if (bus.PWRITE !== 1'b1) begin bad++; $display("FAIL wr_pwrite got=%b exp=1", bus.PWRITE); end
    total++; if (bus.PPROT !== 3'b010) begin bad++; $display("FAIL wr_pprot got=%b exp=010", bus.PPROT); end
    tick(1); // ACCESS
    total++; if (bus.PSELx !== 4'b0100) begin bad++; $display("FAIL wr_psel_acc got=%b exp=0100", bus.PSELx); end
    total++; if (bus.PENABLE !== 1'b1) begin bad++; $display("FAIL wr_pen_acc got=%b exp=1", bus.PENABLE); end
    tick(1); // RESP
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL wr_rsp_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL wr_rsp_err got=%b exp=0", bus.rsp_err); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
    total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL wr_psel_resp got=%b exp=0000", bus.PSELx); end
    bus.PREADY = 1'b0; bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_drop got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.PWAKEUP !== 1'b1) begin bad++; $display("FAIL wr_hold1 got=%b exp=1", bus.PWAKEUP); end
    tick(1);
    total++; if (bus.PWAKEUP !== 1'b1) begin bad++; $display("FAIL wr_hold2 got=%b exp=1", bus.PWAKEUP); end
    tick(1);
    total++; if (bus.PWAKEUP !== 1'b0) begin bad++; $display("FAIL wr_hold_drop got=%b exp=0", bus.PWAKEUP); end
  endtask

  task automatic test_read_hold();
    issue(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'd1);
    tick(1); // WAKE
    bus.req_valid = 1'b0;
    total++; if (bus.PSTRB !== 4'h0) begin bad++; $display("FAIL rd_pstrb got=%h exp=0", bus.PSTRB); end
    total++; if (bus.PWRITE !== 1'b0) begin bad++; $display("FAIL rd_pwrite got=%b exp=0", bus.PWRITE); end
    tick(1); // SETUP
    total++; if (bus.PSELx !== 4'b0010) begin bad++; $display("FAIL rd_psel got=%b exp=0010", bus.PSELx); end
    tick(3); // third wait state
    total++; if (bus.PENABLE !== 1'b1) begin bad++; $display("FAIL rd_pen_wait got=%b exp=1", bus.PENABLE); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_rsp got=%b exp=0", bus.rsp_valid); end
    tick(1);
    bus.PREADY = 1'b1; bus.PRDATA = 32'h1234_5678;
    tick(1); // RESP
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_rsp_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_rdata got=%h exp=12345678", bus.rsp_rdata); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%b exp=0", bus.rsp_err); end
    bus.PREADY = 1'b0; bus.PRDATA = 32'hDEAD_BEEF; bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    total++; if (bus.PWAKEUP !== 1'b1) begin bad++; $display("FAIL rd_wake_gap got=%b exp=1", bus.PWAKEUP); end
    issue(1'b0, 32'h24, 32'h0, 4'h0, 3'd1);
    tick(1); // straight to SETUP
    bus.req_valid = 1'b0;
    total++; if (bus.PSELx !== 4'b0010) begin bad++; $display("FAIL rd2_skip_wake_psel got=%b exp=0010", bus.PSELx); end
    total++; if (bus.PENABLE !== 1'b0) begin bad++; $display("FAIL rd2_setup_pen got=%b exp=0", bus.PENABLE); end
    total++; if (bus.PADDR !== 32'h24) begin bad++; $display("FAIL rd2_paddr got=%h exp=00000024", bus.PADDR); end
    bus.PREADY = 1'b1; bus.PRDATA = 32'hCAFE_F00D;
    tick(1); // ACCESS
    total++; if (bus.PENABLE !== 1'b1) begin bad++; $display("FAIL rd2_pen got=%b exp=1", bus.PENABLE); end
    tick(1); // RESP, 3 cycles after accept
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rd2_rsp_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rd2_rdata got=%h exp=cafef00d", bus.rsp_rdata); end
    total++; if (bus.PWAKEUP !== 1'b1) begin bad++; $display("FAIL rd2_wake got=%b exp=1", bus.PWAKEUP); end
    bus.PREADY = 1'b0; bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    tick(3);
  endtask

  task automatic test_slverr_stall();
    issue(1'b1, 32'h30, 32'h0BAD_0BAD, 4'h3, 3'd0);
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b1;
    tick(1);
    bus.req_valid = 1'b0;
    tick(3); // RESP
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL se_valid_%0d got=%b exp=1", k, bus.rsp_valid); end
      total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL se_err_%0d got=%b exp=1", k, bus.rsp_err); end
      total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL se_rdata_%0d got=%h exp=0", k, bus.rsp_rdata); end
      total++; if (bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL se_to_%0d got=%b exp=0", k, bus.rsp_timeout); end
      total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL se_psel_%0d got=%b exp=0000", k, bus.PSELx); end
      tick(1);
    end
    bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL se_release got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL se_ready got=%b exp=1", bus.req_ready); end
    tick(3);
  endtask

  task automatic test_timeout();
    int n;
    int acc;
    issue(1'b0, 32'h40, 32'h0, 4'h0, 3'd3);
    bus.PRDATA = 32'hFFFF_FFFF;
    tick(1);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.PENABLE !== 1'b1 && n < 10) begin tick(1); n++; end
    total++; if (n >= 10) begin bad++; $display("FAIL to_no_access got=%0d exp=<10", n); end
    acc = 0;
    while (bus.PENABLE === 1'b1 && acc < 40) begin
      total++; if (bus.PSELx !== 4'b1000) begin bad++; $display("FAIL to_psel_acc got=%b exp=1000", bus.PSELx); end
      tick(1); acc++;
    end
    total++; if (acc !== 8) begin bad++; $display("FAIL to_access_cycles got=%0d exp=8", acc); end
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL to_rsp_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus.rsp_err); end
    total++; if (bus.rsp_timeout !== 1'b1) begin bad++; $display("FAIL to_timeout got=%b exp=1", bus.rsp_timeout); end
    total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", bus.rsp_rdata); end
    total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL to_psel got=%b exp=0000", bus.PSELx); end
    bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    tick(3);
  endtask

  task automatic test_decode_err();
    total++; if (bus.PWAKEUP !== 1'b0) begin bad++; $display("FAIL de_wake_pre got=%b exp=0", bus.PWAKEUP); end
    issue(1'b1, 32'h50, 32'h1, 4'hF, 3'(NS));
    tick(1);
    bus.req_valid = 1'b0;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL de_rsp_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL de_err got=%b exp=1", bus.rsp_err); end
    total++; if (bus.rsp_timeout !== 1'b0) begin bad++; $display("FAIL de_timeout got=%b exp=0", bus.rsp_timeout); end
    total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL de_psel got=%b exp=0000", bus.PSELx); end
    total++; if (bus.PWAKEUP !== 1'b0) begin bad++; $display("FAIL de_wake got=%b exp=0", bus.PWAKEUP); end
    bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    total++; if (bus.PWAKEUP !== 1'b0) begin bad++; $display("FAIL de_wake_post got=%b exp=0", bus.PWAKEUP); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL de_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(1'b1, 32'h44, 32'h1122_3344, 4'hF, 3'd3);
    tick(1);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.PENABLE !== 1'b1 && n < 10) begin tick(1); n++; end
    total++; if (n >= 10) begin bad++; $display("FAIL rm_no_access got=%0d exp=<10", n); end
    #2 PRESETn = 1'b0;
    #1;
    total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL rm_psel got=%b exp=0000", bus.PSELx); end
    total++; if (bus.PENABLE !== 1'b0) begin bad++; $display("FAIL rm_pen got=%b exp=0", bus.PENABLE); end
    total++; if (bus.PWAKEUP !== 1'b0) begin bad++; $display("FAIL rm_wake got=%b exp=0", bus.PWAKEUP); end
    total++; if (bus.PADDR !== 32'h0) begin bad++; $display("FAIL rm_paddr got=%h exp=0", bus.PADDR); end
    total++; if (bus.PWDATA !== 32'h0) begin bad++; $display("FAIL rm_pwdata got=%h exp=0", bus.PWDATA); end
    total++; if (bus.PSTRB !== 4'h0) begin bad++; $display("FAIL rm_pstrb got=%h exp=0", bus.PSTRB); end
    total++; if (bus.PWRITE !== 1'b0) begin bad++; $display("FAIL rm_pwrite got=%b exp=0", bus.PWRITE); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", bus.req_ready); end
    bus.PREADY = 1'b1;
    tick(1);
    PRESETn = 1'b1;
    tick(2);
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_discard got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_rel got=%b exp=1", bus.req_ready); end
    total++; if (bus.PSELx !== 4'b0000) begin bad++; $display("FAIL rm_psel_rel got=%b exp=0000", bus.PSELx); end
    bus.PREADY = 1'b0;
  endtask

`ifdef APB_REQ_PARITY_EN
  task automatic test_parity();
    int n;
    issue(1'b0, 32'h60, 32'h0, 4'h0, 3'd0);
    bus.PREADY = 1'b1; bus.PRDATA = 32'h0F0F_0F0F; rdchk_flip = 4'b0001;
    tick(1);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick(1); n++; end
    total++; if (n >= 10) begin bad++; $display("FAIL par_no_rsp got=%0d exp=<10", n); end
    total++; if (bus.rsp_parerr !== 1'b1) begin bad++; $display("FAIL par_parerr got=%b exp=1", bus.rsp_parerr); end
    total++; if (bus.rsp_err !== 1'b1) begin bad++; $display("FAIL par_err got=%b exp=1", bus.rsp_err); end
    bus.PREADY = 1'b0; rdchk_flip = '0; bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_slverr_stall();
    test_timeout();
    test_decode_err();
    test_reset_mid();
`ifdef APB_REQ_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
